// File: rtl/rr_mux4_arbiter_pkg.sv
// Shared encodings for the round-robin 4:1 mux arbiter.
package rr_mux4_arbiter_pkg;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } state_e;

   localparam logic [1:0] REQ_A = 2'd0;
   localparam logic [1:0] REQ_B = 2'd1;
   localparam logic [1:0] REQ_C = 2'd2;
   localparam logic [1:0] REQ_D = 2'd3;

endpackage

// File: rtl/rr_mux4_arbiter_mux4.sv
// 4:1 data mux built from two levels of 2:1 stages.
module rr_mux4_arbiter_mux4 #(
   parameter int WIDTH = 1
) (
   input  logic [1:0]       sel_i,
   input  logic [WIDTH-1:0] d0_i,
   input  logic [WIDTH-1:0] d1_i,
   input  logic [WIDTH-1:0] d2_i,
   input  logic [WIDTH-1:0] d3_i,
   output logic [WIDTH-1:0] y_o
);

   logic [WIDTH-1:0] lo;
   logic [WIDTH-1:0] hi;

   // First level picks within each pair on sel[0]; second level picks the pair on sel[1].
   assign lo  = sel_i[0] ? d1_i : d0_i;
   assign hi  = sel_i[0] ? d3_i : d2_i;
   assign y_o = sel_i[1] ? hi : lo;

endmodule

// File: rtl/rr_mux4_arbiter.sv
// Round-robin arbiter with hold limit driving the select of a shared 4:1 mux.
//
// state   | meaning
// ST_IDLE | no owner, grant = 0
// ST_BUSY | grant[sel] = 1, hold_q counts consecutive cycles of this grant
module rr_mux4_arbiter
   import rr_mux4_arbiter_pkg::*;
#(
   parameter int WIDTH    = 1,
   parameter int MAX_HOLD = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [3:0]       req,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [WIDTH-1:0] c,
   input  logic [WIDTH-1:0] d,
   output logic [3:0]       grant,
   output logic [1:0]       sel,
   output logic [WIDTH-1:0] y,
   output logic             y_valid
);

   localparam int              HW        = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
   localparam logic [HW-1:0]   HOLD_LAST = HW'(MAX_HOLD - 1);

   state_e        state_q, state_d;
   logic [3:0]    grant_q, grant_d;
   logic [1:0]    sel_q, sel_d;
   logic [1:0]    last_q, last_d;
   logic [HW-1:0] hold_q, hold_d;
   logic          valid_q, valid_d;
   logic [2:0]    pick;
   logic          keep;

   // Returns {found, index}; search starts one past the last winner and wraps,
   // so the last winner itself is considered only when nobody else is asking.
   function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] last);
      logic [2:0] res;
      logic [1:0] idx;
      res = 3'b000;
      for (int i = 1; i <= 4; i++) begin
         idx = last + 2'(i);
         if (r[idx] && !res[2]) res = {1'b1, idx};
      end
      return res;
   endfunction

   // Next-state: keep the owner while it asks and is under the limit, otherwise re-arbitrate.
   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      sel_d   = sel_q;
      last_d  = last_q;
      hold_d  = hold_q;
      valid_d = valid_q;
      pick    = rr_pick(req, last_q);
      keep    = (state_q == ST_BUSY) && req[sel_q] && (hold_q != HOLD_LAST);
      if (keep) begin
         hold_d = hold_q + HW'(1);
      end else if (pick[2]) begin
         state_d = ST_BUSY;
         sel_d   = pick[1:0];
         last_d  = pick[1:0];
         grant_d = 4'(4'b0001 << pick[1:0]);
         hold_d  = '0;
         valid_d = 1'b1;
      end else begin
         // sel is left alone on the way to idle
         state_d = ST_IDLE;
         grant_d = 4'b0000;
         hold_d  = '0;
         valid_d = 1'b0;
      end
   end

   // State and registered outputs; synchronous reset wins over everything.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         grant_q <= 4'b0000;
         sel_q   <= REQ_A;
         last_q  <= REQ_D;
         hold_q  <= '0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         sel_q   <= sel_d;
         last_q  <= last_d;
         hold_q  <= hold_d;
         valid_q <= valid_d;
      end
   end

   assign grant   = grant_q;
   assign sel     = sel_q;
   assign y_valid = valid_q;

   rr_mux4_arbiter_mux4 #(.WIDTH(WIDTH)) u_mux (
      .sel_i (sel_q),
      .d0_i  (a),
      .d1_i  (b),
      .d2_i  (c),
      .d3_i  (d),
      .y_o   (y)
   );

endmodule

// File: tb/tb_rr_mux4_arbiter.sv
module tb_rr_mux4_arbiter;

   logic       clk;
   logic       rst;
   logic [3:0] req;
   logic [0:0] a, b, c, d;
   logic [3:0] grant;
   logic [1:0] sel;
   logic [0:0] y;
   logic       y_valid;

   int n_assert = 0;
   int n_fail   = 0;

   rr_mux4_arbiter #(.WIDTH(1), .MAX_HOLD(4)) dut (
      .clk     (clk),
      .rst     (rst),
      .req     (req),
      .a       (a),
      .b       (b),
      .c       (c),
      .d       (d),
      .grant   (grant),
      .sel     (sel),
      .y       (y),
      .y_valid (y_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      logic [1:0] es;

      // reset with all requesting
      rst = 1'b1; req = 4'b1111;
      a = 1'b1; b = 1'b0; c = 1'b0; d = 1'b0;
      step();
      step();
      check("rst_grant", 32'(grant), 32'h0);
      check("rst_sel", 32'(sel), 32'h0);
      check("rst_valid", 32'(y_valid), 32'h0);
      check("rst_y_is_a", 32'(y), 32'h1);

      // rotation: 4 cycles each a,b,c,d then back to a
      a = 1'b0; b = 1'b1; c = 1'b0; d = 1'b1;
      rst = 1'b0;
      for (int i = 0; i < 17; i++) begin
         step();
         es = 2'((i / 4) % 4);
         check("rot_grant", 32'(grant), 32'(4'b0001 << es));
         check("rot_sel", 32'(sel), 32'(es));
         check("rot_valid", 32'(y_valid), 32'h1);
         check("rot_y", 32'(y), 32'(es[0]));
      end

      // all drop, then re-request b
      req = 4'b0000;
      step();
      check("drop_grant", 32'(grant), 32'h0);
      check("drop_valid", 32'(y_valid), 32'h0);
      check("drop_sel_keep", 32'(sel), 32'h0);
      req = 4'b0010;
      step();
      check("rereq_grant", 32'(grant), 32'h2);
      check("rereq_sel", 32'(sel), 32'h1);
      check("rereq_valid", 32'(y_valid), 32'h1);

      // early release by b: d next, then a after d's hold limit
      req = 4'b1001;
      for (int i = 0; i < 5; i++) begin
         step();
         es = (i < 4) ? 2'd3 : 2'd0;
         check("early_sel", 32'(sel), 32'(es));
         check("early_grant", 32'(grant), 32'(4'b0001 << es));
      end

      // single requester c: continuous grant through hold-limit re-grant
      req = 4'b0100; c = 1'b1;
      for (int i = 0; i < 10; i++) begin
         step();
         check("single_grant", 32'(grant), 32'h4);
         check("single_valid", 32'(y_valid), 32'h1);
         check("single_y", 32'(y), 32'h1);
      end
      step();
      check("single_grant_h2", 32'(grant), 32'h4);

      // reset mid-grant (c at hold count 2)
      rst = 1'b1;
      step();
      check("midrst_grant", 32'(grant), 32'h0);
      check("midrst_valid", 32'(y_valid), 32'h0);
      check("midrst_sel", 32'(sel), 32'h0);
      rst = 1'b0;
      step();
      check("postrst_grant", 32'(grant), 32'h4);
      check("postrst_sel", 32'(sel), 32'h2);

      // hold count restarted: c keeps 3 more cycles, then a
      req = 4'b0101;
      for (int i = 0; i < 4; i++) begin
         step();
         es = (i < 3) ? 2'd2 : 2'd0;
         check("hold_restart_sel", 32'(sel), 32'(es));
         check("hold_restart_grant", 32'(grant), 32'(4'b0001 << es));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/rr_mux4_arbiter.md
Name: rr_mux4_arbiter

Overview:
- Round-robin arbiter and sequencer for a shared 4:1 select mux.
- Four requesters (a, b, c, d) compete for one output channel. The block decides who owns it, drives the mux select and flags valid output.
- A hold limit stops any single requester from holding the channel indefinitely.
- Sits directly in front of the existing 4:1 mux built from 2:1 stages; it replaces the hand-driven select used today.

Parameters:
WIDTH, 1, data width of each requester input and of y
MAX_HOLD, 4, maximum consecutive grant cycles per requester before forced re-arbitration (>=1)

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous reset, active-high
req  input  4  request lines; bit0=a, bit1=b, bit2=c, bit3=d
a  input  WIDTH  requester 0 data
b  input  WIDTH  requester 1 data
c  input  WIDTH  requester 2 data
d  input  WIDTH  requester 3 data
grant  output  4  one-hot grant, registered; all zero when idle
sel  output  2  registered mux select = index of granted requester
y  output  WIDTH  mux output = data selected by sel (combinational from sel and data)
y_valid  output  1  high while any grant is active (= |grant)

Behaviour:
- Reset (rst=1 at clk edge): state=IDLE, grant=4'b0000, sel=2'b00, y_valid=0, last=2'd3, hold_cnt=0. Since sel=0, y follows a. rst has priority over every other event.
- States:
  - IDLE: no owner.
  - BUSY: grant[sel]=1.
- Priority order: search starts at last+1 mod 4 and wraps (3->0). last holds the index of the most recent grant.
- IDLE:
  - If req != 0, the next edge goes to BUSY, sets grant to the winner, sel=winner, last=winner, hold_cnt=0.
  - Otherwise stay in IDLE.
- Latency: req rising before edge n gives grant/sel/y_valid valid after edge n (one cycle).
- BUSY, evaluated each edge:
  - Keep: req[sel]=1 and hold_cnt<MAX_HOLD-1 -> keep grant, hold_cnt+1.
  - Release: req[sel]=0, or hold_cnt==MAX_HOLD-1. Re-arbitrate at the same edge over the current req, starting from last+1.
    - Any winner -> new grant, hold_cnt=0, no idle bubble.
    - req==0 -> IDLE, grant=0, y_valid=0, sel keeps its value.
  - At the hold limit, if the only active request is the current owner, it wins again (hold_cnt restarts at 0). y_valid stays high.
- Requests from non-owners never preempt before release.
- req changes take effect only at edges. Glitches between edges are ignored.
- grant is always one-hot or zero. sel always equals the index of the set grant bit while BUSY.
- hold_cnt width: clog2(MAX_HOLD), minimum 1 bit. MAX_HOLD=1 means re-arbitrate every cycle (pure round-robin per cycle).
- Reset mid-BUSY: grant drops to 0 at that edge. The first grant after reset goes to the lowest-index active requester.

Decomposition:
- Shared package/include: state encodings (ST_IDLE=1'b0, ST_BUSY=1'b1) and requester index constants (REQ_A..REQ_D = 0..3).
- One sub-module: reuse the existing 4:1 mux (two-level 2:1 structure), instantiated once with WIDTH-wide data, driven by sel, producing y.
- Round-robin next-winner logic stays inline as a combinational function.

Test Plan:
- Reset: rst=1 for 2 cycles, req=4'b1111 -> grant=0000, sel=00, y_valid=0. First edge after rst=0 -> grant=0001, sel=00.
- Single requester: req=4'b0100 held 10 cycles, MAX_HOLD=4 -> grant=0100 every cycle, y_valid continuous, y=c. Hold-limit re-grant occurs with no bubble.
- Rotation: req=4'b1111 held, MAX_HOLD=4, data a=0 b=1 c=0 d=1 -> sel stays 0,1,2,3 for 4 cycles each, then wraps to 0. y=0,1,0,1 per phase.
- Early release: owner b (sel=01), drop req[1] while req=4'b1001 -> next edge sel=11 (d, search from 2). Following release goes to a.
- All drop: BUSY with req going to 0000 -> next edge grant=0000, y_valid=0. Re-request req=0010 -> grant=0010 after one edge.
- Reset mid-grant: owner c at hold_cnt=2, assert rst -> grant=0000 at that edge, last=3. After release with req=4'b0100, grant=0100 and hold_cnt restarts at 0.
